// File: rtl/uart_apb_master.sv
// APB3 initiator for a CoreUARTapb-style UART: programs CTRL1/CTRL2, then polls STATUS
// and moves bytes between the UART and valid/ready streams. Optional: UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master #(
  parameter logic [12:0] BAUD_VAL   = 13'd1,
  parameter bit          DATA8      = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter logic [4:0]  A_TXDATA   = 5'h00,
  parameter logic [4:0]  A_RXDATA   = 5'h04,
  parameter logic [4:0]  A_CTRL1    = 5'h08,
  parameter logic [4:0]  A_CTRL2    = 5'h0C,
  parameter logic [4:0]  A_STATUS   = 5'h10
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       cfg_done
);

  localparam logic [7:0] CTRL1_VAL = BAUD_VAL[7:0];
  localparam logic [7:0] CTRL2_VAL = {BAUD_VAL[12:8], PARITY_ODD, PARITY_EN, DATA8};

  typedef enum logic [2:0] {ST_CFG1, ST_CFG2, ST_STAT, ST_RXRD, ST_TXWR} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

  state_e     state_q, state_d, tgt;
  phase_e     phase_q, phase_d;
  logic [4:0] paddr_q, paddr_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [3:0] err_q, err_d;
  logic       cfg_done_q, cfg_done_d;
  logic       complete, to_hit, launch;

  assign complete = (phase_q == PH_ACCESS) && PREADY;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (phase_q == PH_SETUP)
      to_cnt_d = '0;
    else if (phase_q == PH_ACCESS && !PREADY)
      to_cnt_d = to_cnt_q + 8'd1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end

  // Counter reads 254 during the 255th stalled ACCESS cycle.
  assign to_hit = (phase_q == PH_ACCESS) && !PREADY && (to_cnt_q == 8'd254);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_d      = err_clr ? '0 : err_q;
    cfg_done_d = cfg_done_q;
    launch     = 1'b0;
    tgt        = state_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (phase_q)
      PH_IDLE:  launch = 1'b1;
      PH_SETUP: phase_d = PH_ACCESS;
      PH_ACCESS: begin
        if (complete) begin
          launch = 1'b1;
          if (PSLVERR) err_d[3] = 1'b1;
          case (state_q)
            ST_CFG1: tgt = ST_CFG2;
            ST_CFG2: begin
              tgt        = ST_STAT;
              cfg_done_d = 1'b1;
            end
            ST_STAT: begin
              err_d[2:0] = err_d[2:0] | PRDATA[4:2];
              if (PRDATA[1] && !rx_valid_q)  tgt = ST_RXRD;
              else if (PRDATA[0] && tx_valid) tgt = ST_TXWR;
              else                            tgt = ST_STAT;
            end
            ST_RXRD: begin
              rx_data_d  = PRDATA;
              rx_valid_d = 1'b1;
              tgt        = ST_STAT;
            end
            default: tgt = ST_STAT;
          endcase
        end else if (to_hit) begin
          // Abandoned transfer: one cycle with PSEL low, then IDLE relaunches state_d.
          err_d[3] = 1'b1;
          phase_d  = PH_IDLE;
          state_d  = (state_q == ST_CFG1 || state_q == ST_CFG2) ? ST_CFG1 : ST_STAT;
        end
      end
      default: phase_d = PH_IDLE;
    endcase

    if (launch) begin
      state_d = tgt;
      phase_d = PH_SETUP;
      case (tgt)
        ST_CFG1: begin paddr_d = A_CTRL1;  pwrite_d = 1'b1; pwdata_d = CTRL1_VAL; end
        ST_CFG2: begin paddr_d = A_CTRL2;  pwrite_d = 1'b1; pwdata_d = CTRL2_VAL; end
        ST_STAT: begin paddr_d = A_STATUS; pwrite_d = 1'b0; pwdata_d = '0;        end
        ST_RXRD: begin paddr_d = A_RXDATA; pwrite_d = 1'b0; pwdata_d = '0;        end
        default: begin paddr_d = A_TXDATA; pwrite_d = 1'b1; pwdata_d = tx_data;   end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_CFG1;
      phase_q    <= PH_IDLE;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign PSEL      = (phase_q != PH_IDLE);
  assign PENABLE   = (phase_q == PH_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign tx_ready  = complete && (state_q == ST_TXWR) && !PRESET;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign err_flags = err_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
- APB3 initiator that owns a CoreUARTapb-style UART slave: 5-bit PADDR, 8-bit data.
- After reset it programs the baud and frame control registers, then polls the status register forever.
- It moves received bytes onto a valid/ready output stream and bytes from a valid/ready input stream into the TX data register.
- Sits between fabric byte-stream logic and the UART's APB port, replacing a CPU bus master.

Parameters:
BAUD_VAL, 13'd1, 13-bit baud divisor; [7:0] go to CTRL1, [12:8] to CTRL2[7:3]
DATA8, 1, CTRL2[0]: 1 = 8 data bits, 0 = 7
PARITY_EN, 0, CTRL2[1]: parity enable
PARITY_ODD, 0, CTRL2[2]: 1 = odd parity, 0 = even
A_TXDATA, 5'h00 / A_RXDATA, 5'h04 / A_CTRL1, 5'h08 / A_CTRL2, 5'h0C / A_STATUS, 5'h10: register addresses

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  5  APB address
PWDATA  out  8  APB write data
PRDATA  in  8  APB read data
PREADY  in  1  APB ready (wait states allowed)
PSLVERR  in  1  APB slave error
tx_data  in  8  byte to transmit; stable while tx_valid=1
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle pulse: tx_data consumed
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid; held until rx_ready
rx_ready  in  1  downstream accepts rx_data
err_flags  out  4  sticky {pslverr, framing, overflow, parity}
err_clr  in  1  clears err_flags
cfg_done  out  1  high once both control writes complete

Behaviour:
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, tx_ready=0, rx_valid=0, rx_data=0, err_flags=0, cfg_done=0.
- Every transfer is a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1. PADDR, PWRITE and PWDATA are constant across the whole transfer.
- Completion cycle = ACCESS with PREADY=1. PRDATA and PSLVERR are sampled only in that cycle.
- The next SETUP starts in the cycle after completion. There is no idle cycle between back-to-back transfers.
- FSM states: CFG1 -> CFG2 -> STAT -> {RXRD | TXWR | STAT}. Each state has a SETUP and an ACCESS substate.
  - CFG1: write CTRL1 = BAUD_VAL[7:0].
  - CFG2: write CTRL2 = {BAUD_VAL[12:8], PARITY_ODD, PARITY_EN, DATA8}. cfg_done is set in the cycle after CFG2 completes.
  - STAT: read STATUS. Bit0 = TXRDY, bit1 = RXRDY, bit2 = parity error, bit3 = overflow, bit4 = framing error.
  - STAT decision, in priority order:
    - if RXRDY=1 and rx_valid=0 -> RXRD;
    - else if TXRDY=1 and tx_valid=1 -> TXWR;
    - else -> STAT.
    - RX has priority over TX.
  - RXRD: read RXDATA. On completion, rx_data <= PRDATA and rx_valid <= 1 (visible the next cycle). Then -> STAT.
  - TXWR: PWDATA = tx_data, captured at SETUP. tx_ready = 1 in the completion cycle only. Then -> STAT.
- rx_valid clears on the cycle rx_valid & rx_ready. RXRD is never entered while rx_valid=1, so the holding register cannot overflow. UART-side overflow is reported via err_flags[1].
- err_flags: on each STAT completion, OR in status bits {4,3,2} to err_flags[2:0]. On any completion with PSLVERR=1, set err_flags[3].
  - If err_clr and a new error occur in the same cycle, the set wins.
  - A PSLVERR on any transfer does not retry; the FSM advances as if the transfer succeeded.
- PRESET mid-transfer: at the next edge PSEL and PENABLE drop to 0, the transfer is abandoned, rx_valid clears, and configuration restarts from CFG1.
- tx_valid dropping before the TXWR SETUP cycle: the FSM has already committed, so protocol requires tx_valid to stay high until tx_ready.

Optional Feature:
- Macro: UART_APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs during ACCESS. After 255 consecutive cycles with PREADY=0, the transfer is forcibly terminated (PSEL=PENABLE=0 next cycle).
  - err_flags[3] is set, read data is discarded, rx_valid is not set, tx_ready is not pulsed, and the FSM returns to STAT (to CFG1 if the timeout hit during CFG1/CFG2).
- Undefined: the FSM waits indefinitely for PREADY; no counter logic is generated.

Test Plan:
- Config: BAUD_VAL=13'h1A5, DATA8=1, PARITY_EN=1, PARITY_ODD=0, PREADY tied 1 -> write 0x08<=0xA5, then 0x0C<=0x0B. cfg_done=1 on the 5th cycle after reset release. Status polling at 0x10 follows back-to-back.
- RX path: slave returns STATUS=0x02, then RXDATA=0x5C, with rx_ready=0 -> rx_valid=1 and rx_data=0x5C. No further 0x04 reads while held, even with STATUS=0x02. After a one-cycle rx_ready pulse, the next STATUS=0x02 causes a 0x04 read.
- TX path: tx_valid=1, tx_data=0x3E, STATUS=0x01 -> write 0x00<=0x3E. tx_ready pulses exactly once in the completion cycle. STATUS=0x03 with rx_valid=0 -> RX read is issued before TX.
- Wait states: PREADY=0 for 3 ACCESS cycles on a TX write -> PSEL/PENABLE/PADDR/PWDATA stable for 4 ACCESS cycles. tx_ready only in the 4th.
- Errors: STATUS=0x15 -> err_flags=4'b0101. A PSLVERR=1 completion -> err_flags[3]=1. err_clr=1 on a clean cycle -> 0. PRESET during an ACCESS -> PSEL=0 next cycle and CTRL1 is rewritten.
- With UART_APB_MASTER_TIMEOUT_EN: PREADY held 0 -> PSEL drops after 255 ACCESS cycles, err_flags[3]=1, and STATUS polling resumes.
